// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the sequence pattern detector
package seq_det_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DET_NONE = 2'd0,
        DET_EVEN = 2'd1,
        DET_ODD  = 2'd2
    } det_t;

    localparam int DET_W = 2;

endpackage

// File: rtl/seq_window.sv
// rtl/seq_window.sv - symbol shift window with saturating fill counter and flush
module seq_window #(
    parameter int W  = 3,
    parameter int N  = 4,
    parameter int PW = $clog2(N+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift_en,
    input  logic           flush,
    input  logic [W-1:0]   inp,
    output logic [N*W-1:0] win_next,
    output logic [PW-1:0]  progress
);

    logic [N*W-1:0] win;

    // Newest symbol lands in the top slot so slot 0 always holds the oldest.
    assign win_next = {inp, win[N*W-1:W]};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            win      <= '0;
            progress <= '0;
        end else if (shift_en) begin
            win <= win_next;
            if (progress != PW'(N))
                progress <= progress + PW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable N-symbol pattern detector with sum and match count
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int W  = 3,
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            inp,
    input  logic                    in_valid,
    input  logic [N*W-1:0]          pattern,
    input  logic                    overlap,
    input  logic                    clear,
    output logic                    done,
    output logic [DET_W-1:0]        detect,
    output logic [W+$clog2(N)-1:0]  sum,
    output logic [$clog2(N+1)-1:0]  progress,
    output logic [CW-1:0]           match_cnt
);

    localparam int PW = $clog2(N+1);
    localparam int SW = W + $clog2(N);

    state_t         state, state_nxt;
    logic [N*W-1:0] win_next;
    logic           accept;
    logic           full_after;
    logic           hit;
    logic           restart;
    logic [SW-1:0]  sum_next;

    // clear takes priority over a simultaneous symbol, which is dropped.
    assign accept     = in_valid && !clear;
    assign full_after = (state == S_SCAN) || (progress == PW'(N-1));
    assign hit        = accept && full_after && (win_next == pattern);
    assign restart    = hit && !overlap;

    seq_window #(
        .W  (W),
        .N  (N),
        .PW (PW)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .flush    (clear || restart),
        .inp      (inp),
        .win_next (win_next),
        .progress (progress)
    );

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N; i++)
            sum_next = sum_next + SW'(win_next[i*W +: W]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear || restart)
            state_nxt = S_FILL;
        else if (accept && full_after)
            state_nxt = S_SCAN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            detect    <= DET_NONE;
            sum       <= '0;
            match_cnt <= '0;
        end else begin
            done   <= hit;
            detect <= DET_NONE;
            if (hit) begin
                detect <= inp[0] ? DET_ODD : DET_EVEN;
                sum    <= sum_next;
                if (match_cnt != {CW{1'b1}})
                    match_cnt <= match_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - randomized and directed checks against a queue-based model
module tb_seq_pattern_detector;

    localparam int W = 3;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   inp;
    logic           in_valid;
    logic [N*W-1:0] pattern;
    logic           overlap;
    logic           clear;

    logic           done,      done_s;
    logic [1:0]     detect,    detect_s;
    logic [4:0]     sum,       sum_s;
    logic [2:0]     progress,  progress_s;
    logic [7:0]     match_cnt;
    logic [1:0]     match_cnt_s;

    always #5 clk = ~clk;

    seq_pattern_detector #(.W(W), .N(N), .CW(8)) dut (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .pattern(pattern),
        .overlap(overlap), .clear(clear), .done(done), .detect(detect), .sum(sum),
        .progress(progress), .match_cnt(match_cnt)
    );

    seq_pattern_detector #(.W(W), .N(N), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .pattern(pattern),
        .overlap(overlap), .clear(clear), .done(done_s), .detect(detect_s), .sum(sum_s),
        .progress(progress_s), .match_cnt(match_cnt_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: queue of symbols accepted since the last flush, newest at the back.
    int q[$];
    int exp_done, exp_det, exp_sum, exp_cnt, exp_cnt_s, exp_prog;
    int done_seen;

    task automatic update_model();
        int m;
        if (rst) begin
            q.delete();
            exp_done = 0; exp_det = 0; exp_sum = 0; exp_cnt = 0; exp_cnt_s = 0;
        end else if (clear) begin
            q.delete();
            exp_done = 0; exp_det = 0;
        end else if (in_valid) begin
            q.push_back(int'(inp));
            if (q.size() > N) void'(q.pop_front());
            m = (q.size() == N);
            if (m)
                for (int i = 0; i < N; i++)
                    if (q[i] != int'(pattern[i*W +: W])) m = 0;
            exp_done = m;
            exp_det  = 0;
            if (m) begin
                exp_det = (inp % 2 == 1) ? 2 : 1;
                exp_sum = 0;
                foreach (q[i]) exp_sum += q[i];
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt_s < 3) exp_cnt_s++;
                if (!overlap) q.delete();
            end
        end else begin
            exp_done = 0; exp_det = 0;
        end
        exp_prog = q.size();
    endtask

    task automatic cycle();
        update_model();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        expect_eq("done",       done,        exp_done);
        expect_eq("detect",     detect,      exp_det);
        expect_eq("sum",        sum,         exp_sum);
        expect_eq("progress",   progress,    exp_prog);
        expect_eq("match_cnt",  match_cnt,   exp_cnt);
        expect_eq("cnt_sat",    match_cnt_s, exp_cnt_s);
        expect_eq("done_sat",   done_s,      exp_done);
    endtask

    task automatic feed(input int sym);
        in_valid = 1'b1; inp = W'(sym);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inp = '0; in_valid = 1'b0; pattern = 12'h530; overlap = 1'b0; clear = 1'b0;
        cycle();
        expect_eq("rst_done", done, 0);
        expect_eq("rst_sum", sum, 0);
        expect_eq("rst_cnt", match_cnt, 0);
        rst = 1'b0;

        // basic match 0,6,4,2
        feed(0); feed(6); feed(4); feed(2);
        expect_eq("t1_done", done, 1);
        expect_eq("t1_detect", detect, 1);
        expect_eq("t1_sum", sum, 12);
        expect_eq("t1_cnt", match_cnt, 1);
        idle(1);
        expect_eq("t1_pulse", done, 0);

        // gapped input with leading junk symbol
        do_reset();
        done_seen = 0;
        feed(1); idle(2); feed(0); idle(1); feed(6); idle(3); feed(4); idle(1); feed(2); idle(2);
        expect_eq("t2_matches", done_seen, 1);
        expect_eq("t2_sum", sum, 12);

        // seven 1s, overlapping then non-overlapping
        do_reset();
        pattern = 12'h249; overlap = 1'b1; done_seen = 0;
        for (int i = 0; i < 7; i++) feed(1);
        idle(1);
        expect_eq("t3_ovl_matches", done_seen, 4);
        expect_eq("t3_ovl_sum", sum, 4);
        do_reset();
        overlap = 1'b0; done_seen = 0;
        for (int i = 0; i < 7; i++) feed(1);
        idle(1);
        expect_eq("t3_novl_matches", done_seen, 1);
        expect_eq("t3_novl_prog", progress, 3);

        // clear racing the completing symbol
        do_reset();
        pattern = 12'h530;
        feed(0); feed(6); feed(4); feed(2);
        feed(0); feed(6); feed(4);
        clear = 1'b1; in_valid = 1'b1; inp = 3'd2; cycle(); clear = 1'b0; in_valid = 1'b0;
        expect_eq("t4_prog", progress, 0);
        expect_eq("t4_done", done, 0);
        expect_eq("t4_sum", sum, 12);
        expect_eq("t4_cnt", match_cnt, 1);

        // reset on the completing cycle
        feed(0); feed(6); feed(4);
        rst = 1'b1; in_valid = 1'b1; inp = 3'd2; cycle(); rst = 1'b0; in_valid = 1'b0;
        expect_eq("t5_done", done, 0);
        expect_eq("t5_prog", progress, 0);
        expect_eq("t5_cnt", match_cnt, 0);

        // saturation of the narrow counter
        do_reset();
        pattern = 12'hFFF; overlap = 1'b1;
        for (int i = 0; i < 11; i++) feed(7);
        expect_eq("t6_cnt8", match_cnt, 8);
        expect_eq("t6_cnt2", match_cnt_s, 3);

        // randomized traffic over a small alphabet so matches are frequent
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < N; k++) pattern[k*W +: W] = W'($urandom_range(0, 1) * 3 + 1);
            end
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            rst      = ($urandom_range(0, 299) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            inp      = W'($urandom_range(0, 1) * 3 + 1);
            if ($urandom_range(0, 15) == 0) inp = W'($urandom);
            cycle();
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
